// File: rtl/seven_segment_display_driver_if.sv
// Display-side bundle for the seven-segment driver:
// four hex digit values in, active-low anode and segment buses out.
interface seven_segment_display_driver_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] anode;
  logic [6:0] LED;

  modport master (
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    input  anode,
    input  LED
  );

  modport slave (
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    output anode,
    output LED
  );
endinterface

// File: rtl/seven_segment_display_driver.sv
// 4-digit common-anode seven-segment scan driver.
// Optional inter-digit blanking: define SSD_GHOST_BLANK_EN.
module seven_segment_display_driver #(
  parameter int REFRESH_BITS = 7,
  parameter int BLANK_CYCLES = 4
) (
  input logic                          clock,
  input logic                          reset,
  seven_segment_display_driver_if.slave bus
);

  localparam int CW = REFRESH_BITS + 2;

`ifdef SSD_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [REFRESH_BITS-1:0] BLANK_LIM =
    REFRESH_BITS'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [3:0]    hex;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          blank;
  logic [3:0]    anode_q;
  logic [6:0]    led_q;

  assign sel = cnt[CW-1 -: 2];

  always_comb begin
    hex  = bus.digit0;
    an_d = 4'b1110;
    unique case (sel)
      2'd0: begin
        hex  = bus.digit0;
        an_d = 4'b1110;
      end
      2'd1: begin
        hex  = bus.digit1;
        an_d = 4'b1101;
      end
      2'd2: begin
        hex  = bus.digit2;
        an_d = 4'b1011;
      end
      2'd3: begin
        hex  = bus.digit3;
        an_d = 4'b0111;
      end
    endcase
  end

  // abcdefg, active-low
  always_comb begin
    seg_d = 7'b1111111;
    unique case (hex)
      4'h0: seg_d = 7'b0000001;
      4'h1: seg_d = 7'b1001111;
      4'h2: seg_d = 7'b0010010;
      4'h3: seg_d = 7'b0000110;
      4'h4: seg_d = 7'b1001100;
      4'h5: seg_d = 7'b0100100;
      4'h6: seg_d = 7'b0100000;
      4'h7: seg_d = 7'b0001111;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0000100;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b1100000;
      4'hC: seg_d = 7'b0110001;
      4'hD: seg_d = 7'b1000010;
      4'hE: seg_d = 7'b0110000;
      4'hF: seg_d = 7'b0111000;
    endcase
  end

  always_comb begin
    blank = BLANK_EN &&
      (cnt[REFRESH_BITS-1:0] < BLANK_LIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      anode_q <= 4'b1111;
      led_q   <= 7'b1111111;
    end else begin
      cnt <= cnt + 1'b1;
      if (blank) begin
        anode_q <= 4'b1111;
        led_q   <= 7'b1111111;
      end else begin
        anode_q <= an_d;
        led_q   <= seg_d;
      end
    end
  end

  assign bus.anode = anode_q;
  assign bus.LED   = led_q;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Randomised bench for seven_segment_display_driver against
// a slot/scan arithmetic reference model.
module tb_seven_segment_display_driver;

  localparam int RB    = 7;
  localparam int BLANK = 4;
  localparam int SLOT  = 1 << RB;

  logic clock;
  logic reset;
  logic [3:0] dig [4];

  int checks;
  int failures;
  int unsigned k;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

`ifdef SSD_GHOST_BLANK_EN
  localparam int NX = 6;
  int         xe [NX] = '{1, 4, 5, 129, 132, 133};
  logic [3:0] xa [NX] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hD};
  logic [6:0] xl [NX] = '{7'h7F, 7'h7F, 7'b1001100,
                          7'h7F, 7'h7F, 7'b0000100};
`else
  localparam int NX = 6;
  int         xe [NX] = '{1, 128, 129, 257, 385, 513};
  logic [3:0] xa [NX] = '{4'hE, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [6:0] xl [NX] = '{7'b1001100, 7'b1001100, 7'b0000100,
                          7'b1001111, 7'b0001000, 7'b1001100};
`endif

  logic [10:0] hist [1:1100];

  seven_segment_display_driver_if ssd ();

  assign ssd.digit0 = dig[0];
  assign ssd.digit1 = dig[1];
  assign ssd.digit2 = dig[2];
  assign ssd.digit3 = dig[3];

  seven_segment_display_driver #(
    .REFRESH_BITS (RB),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ssd.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // c is the count value the edge reflects (edge k -> c = k-1)
  function automatic void model(input int unsigned c,
                                output logic [3:0] a,
                                output logic [6:0] l);
    int unsigned s;
    int unsigned off;
    s   = (c / SLOT) % 4;
    off = c % SLOT;
    a   = ~(4'b0001 << s);
    l   = seg_tab[dig[s]];
`ifdef SSD_GHOST_BLANK_EN
    if (off < BLANK) begin
      a = 4'hF;
      l = 7'h7F;
    end
`else
    if (off > SLOT) a = 4'h0;
`endif
  endfunction

  task automatic step();
    logic [3:0] ea;
    logic [6:0] el;
    logic       ok;
    @(posedge clock);
    k++;
    model(k - 1, ea, el);
    #1;
    chk("anode", {12'd0, ssd.anode}, {12'd0, ea});
    chk("led", {9'd0, ssd.LED}, {9'd0, el});
    ok = ssd.anode inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7};
    chk("onehot", {15'd0, ok}, 16'd1);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, {12'd0, ssd.anode}, 16'h000F);
    chk({tag, "_led"}, {9'd0, ssd.LED}, 16'h007F);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) dig[i] = 4'($urandom);

    repeat (3) begin
      @(posedge clock);
      #1;
      chk_dark("rst_hold");
    end

    dig[0] = 4'h4;
    dig[1] = 4'h9;
    dig[2] = 4'h1;
    dig[3] = 4'hA;
    @(negedge clock);
    reset = 1'b1;

    for (int n = 1; n <= 1100; n++) begin
      step();
      for (int j = 0; j < NX; j++) begin
        if (xe[j] == n) begin
          chk("edge_an", {12'd0, ssd.anode}, {12'd0, xa[j]});
          chk("edge_led", {9'd0, ssd.LED}, {9'd0, xl[j]});
        end
      end
      hist[n] = {ssd.anode, ssd.LED};
      if (n > 512) chk("wrap", {5'd0, hist[n]}, {5'd0, hist[n-512]});
    end

    reset = 1'b0;
    #1;
    chk_dark("rst_async");
    @(posedge clock);
    #1;
    chk_dark("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    k = 0;

    repeat (8) step();
    for (int v = 0; v < 16; v++) begin
      dig[0] = 4'(v);
      step();
      chk("decode", {9'd0, ssd.LED}, {9'd0, seg_tab[v]});
    end

    for (int n = 0; n < 2000; n++) begin
      step();
      if ($urandom_range(7) == 0)
        dig[$urandom_range(3)] = 4'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
